// File: rtl/adder_4bit.sv
// Four-bit ripple-carry adder with combinational and registered results.
// Define ADDER_4BIT_OVF_EN to add the signed-overflow outputs ovf and ovf_q.
module adder_4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [3:0] sum,
  input  logic       cin,
  output logic       cout,
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] sum_q,
  output logic       cout_q
`ifdef ADDER_4BIT_OVF_EN
  ,
  output logic       ovf,
  output logic       ovf_q
`endif
);

  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (c & (a ^ b));
  endfunction

  logic [3:0] sum_s;
  logic       cout_s;
`ifdef ADDER_4BIT_OVF_EN
  logic       c3_s;
  logic       ovf_s;
`endif

  // Ripple chain of four full-adder cells, carry flowing from bit 0 to bit 3.
  always_comb begin
    logic c;
    sum_s  = 4'b0000;
    cout_s = 1'b0;
`ifdef ADDER_4BIT_OVF_EN
    c3_s   = 1'b0;
`endif
    c = cin;
    for (int i = 0; i < 4; i++) begin
`ifdef ADDER_4BIT_OVF_EN
      if (i == 3) begin
        c3_s = c;
      end else begin
        c3_s = c3_s;
      end
`endif
      sum_s[i] = fa_sum(A[i], B[i], c);
      c        = fa_carry(A[i], B[i], c);
    end
    cout_s = c;
  end

`ifdef ADDER_4BIT_OVF_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign ovf_s = c3_s ^ cout_s;
  assign ovf   = ovf_s;
`endif

  assign sum  = sum_s;
  assign cout = cout_s;

  // Pipeline copy of the result; reset wins over capture on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= 4'b0000;
      cout_q <= 1'b0;
`ifdef ADDER_4BIT_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      sum_q  <= sum_s;
      cout_q <= cout_s;
`ifdef ADDER_4BIT_OVF_EN
      ovf_q  <= ovf_s;
`endif
    end
  end

endmodule

// File: tb/tb_adder_4bit.sv
// Self-checking bench for adder_4bit: exhaustive sweep, directed corners and
// random vectors against an arithmetic reference model.
module tb_adder_4bit;

  logic [3:0] A;
  logic [3:0] B;
  logic [3:0] sum;
  logic       cin;
  logic       cout;
  logic       clk;
  logic       rst;
  logic [3:0] sum_q;
  logic       cout_q;
`ifdef ADDER_4BIT_OVF_EN
  logic       ovf;
  logic       ovf_q;
`endif

  int n_cmp;
  int n_err;

  adder_4bit dut (
    .A      (A),
    .B      (B),
    .sum    (sum),
    .cin    (cin),
    .cout   (cout),
    .clk    (clk),
    .rst    (rst),
    .sum_q  (sum_q),
    .cout_q (cout_q)
`ifdef ADDER_4BIT_OVF_EN
    ,
    .ovf    (ovf),
    .ovf_q  (ovf_q)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (A=%0d B=%0d cin=%0d rst=%0d)",
               tag, got, exp, A, B, cin, rst);
    end
  endtask

  // Reference model: plain integer arithmetic.
  function automatic logic [4:0] ref_add(input int a, input int b, input int c);
    int t;
    t = a + b + c;
    return 5'(t);
  endfunction

  function automatic logic ref_ovf(input int a, input int b, input int c);
    int sa;
    int sb;
    int ss;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    ss = sa + sb + c;
    return (ss > 7) || (ss < -8);
  endfunction

  // Drive one vector before the edge, check comb, then registered after the edge.
  task automatic step(input int a, input int b, input int c, input logic r);
    logic [4:0] e;
    logic       eo;
    @(negedge clk);
    A   = 4'(a);
    B   = 4'(b);
    cin = 1'(c);
    rst = r;
    e  = ref_add(a, b, c);
    eo = ref_ovf(a, b, c);
    #1;
    check("sum", {1'b0, sum}, {1'b0, e[3:0]});
    check("cout", {4'b0, cout}, {4'b0, e[4]});
`ifdef ADDER_4BIT_OVF_EN
    check("ovf", {4'b0, ovf}, {4'b0, eo});
`endif
    @(posedge clk);
    #1;
    if (r) begin
      check("sum_q_rst", {1'b0, sum_q}, 5'd0);
      check("cout_q_rst", {4'b0, cout_q}, 5'd0);
`ifdef ADDER_4BIT_OVF_EN
      check("ovf_q_rst", {4'b0, ovf_q}, 5'd0);
`endif
    end else begin
      check("sum_q", {1'b0, sum_q}, {1'b0, e[3:0]});
      check("cout_q", {4'b0, cout_q}, {4'b0, e[4]});
`ifdef ADDER_4BIT_OVF_EN
      check("ovf_q", {4'b0, ovf_q}, {4'b0, eo});
`endif
    end
    check("sum_hold", {1'b0, sum}, {1'b0, e[3:0]});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    A   = 4'd0;
    B   = 4'd0;
    cin = 1'b0;
    rst = 1'b1;

    // Reset state, combinational path unaffected by rst.
    step(5, 7, 0, 1'b1);

    // Directed corners.
    step(5, 7, 0, 1'b0);
    check("ex_5p7", {cout, sum}, 5'd12);
    step(15, 1, 0, 1'b0);
    check("wrap_15p1", {cout, sum}, 5'b1_0000);
    step(15, 15, 1, 1'b0);
    check("max", {cout, sum}, 5'b1_1111);
    step(7, 1, 0, 1'b0);
    check("ovf_7p1", {cout, sum}, 5'd8);
    step(8, 8, 0, 1'b0);
    check("ovf_8p8", {cout, sum}, 5'b1_0000);
    step(3, 2, 0, 1'b0);

    // Latency and mid-stream reset with reload.
    step(9, 4, 1, 1'b0);
    check("lat_sum_q", {1'b0, sum_q}, 5'd14);
    step(9, 4, 1, 1'b1);
    check("rst_sum_comb", {1'b0, sum}, 5'd14);
    step(9, 4, 1, 1'b0);
    check("reload_sum_q", {1'b0, sum_q}, 5'd14);

    // Exhaustive sweep.
    for (int c = 0; c < 2; c++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          step(a, b, c, 1'b0);
        end
      end
    end

    // Random vectors with occasional reset.
    for (int k = 0; k < 200; k++) begin
      step(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
           int'($urandom_range(1, 0)), ($urandom_range(15, 0) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adder_4bit.md
# adder_4bit

Four-bit binary adder with carry-in and carry-out, built as a ripple chain of one-bit full adders. It provides a combinational result for immediate use and a registered copy of the same result for pipelined datapaths. It is a leaf arithmetic block in the digital-system lab datapath, instantiated directly by ALU-style parents and by the exhaustive adder bench.

## Interface

Parameters: none. Width is fixed at 4 bits.

Ports are declared in this order: A, B, sum, cin, cout, clk, rst, sum_q, cout_q, then ovf and ovf_q when present. The order is fixed so that positional instantiations of the first five ports stay valid.

- clk  input  1  system clock; rising-edge active.
- rst  input  1  reset; synchronous and active-high.
- A  input  4  addend, unsigned or two's-complement.
- B  input  4  addend.
- sum  output  4  combinational result, (A + B + cin) mod 16.
- cin  input  1  carry-in into bit 0.
- cout  output  1  combinational carry out of bit 3.
- sum_q  output  4  registered sum.
- cout_q  output  1  registered cout.
- ovf  output  1  combinational signed overflow. Present only with ADDER_4BIT_OVF_EN.
- ovf_q  output  1  registered ovf. Present only with ADDER_4BIT_OVF_EN.

## Operation

- Structure: four full-adder cells.
  - c0 = cin; c(i+1) = carry of cell i; cout = c4.
  - Cell i: s = a ^ b ^ c; carry = (a & b) | (c & (a ^ b)).
- Arithmetic: {cout, sum} = A + B + cin, computed 5 bits wide. No saturation; the result wraps modulo 16.
  - Maximum case: A = 15, B = 15, cin = 1 gives sum = 15, cout = 1.
- sum and cout depend only on A, B and cin. They do not depend on clk or rst, so rst does not affect them.
- Registered path: on each rising clk edge with rst = 0, sum_q <= sum, cout_q <= cout and ovf_q <= ovf. No enable; the registers capture every cycle.
- Signed overflow: ovf = c3 ^ c4. Equivalently, ovf = 1 when A[3] == B[3] and sum[3] != A[3].

## Timing

- sum and cout: zero-cycle, purely combinational. The worst-case path is cin to cout through 4 cells.
- sum_q, cout_q and ovf_q: 1-cycle latency. They reflect the inputs sampled at the previous rising edge.
- Reset: when rst = 1 at a rising edge, sum_q = 0, cout_q = 0 and ovf_q = 0 after that edge.
  - Reset has priority over capture.
  - Asserting rst mid-stream discards the sample taken on that edge.
  - The first capture after release happens on the first edge with rst = 0.
- Before the first reset, registered outputs are undefined (X in simulation). Combinational outputs are valid as soon as the inputs are known.
- Input changes between edges glitch only the combinational outputs, never the registered ones.

## Configuration

- ADDER_4BIT_OVF_EN
  - Defined: the ovf and ovf_q ports exist and behave as described above.
  - Undefined: neither port exists, and no overflow logic or register is synthesised.
  - In both cases sum, cout, sum_q and cout_q behave identically.

## Test plan

- Exhaustive combinational sweep: cin ∈ {0,1}, A and B over 0..15, one vector per 10 time units, compared against the 5-bit reference. Example: A=5, B=7, cin=0 gives sum=12, cout=0.
- Wrap-around: A=15, B=1, cin=0 gives sum=0, cout=1. A=15, B=15, cin=1 gives sum=15, cout=1.
- Signed overflow (with ADDER_4BIT_OVF_EN): A=7, B=1 gives sum=8, ovf=1, cout=0. A=8, B=8 gives sum=0, ovf=1, cout=1. A=3, B=2 gives ovf=0.
- Registered latency: apply A=9, B=4, cin=1 before edge N. After edge N, sum_q=14, cout_q=0. The combinational sum changes immediately.
- Reset mid-operation: with sum_q=14, hold rst=1 across one edge. After that edge sum_q=0, cout_q=0 and ovf_q=0, while sum still shows 14. Release rst; the next edge reloads sum_q=14.
- Build without ADDER_4BIT_OVF_EN: repeat the sweep and check the results are identical and that ovf and ovf_q are absent.
